// File: rtl/mem_stage_pkg.sv
// Shared types for the SampleCPU MEM stage.
// Bus layouts, stall codes and load-type encodings.
package mem_stage_pkg;

  localparam int STALL_W      = 6;
  localparam int EX_TO_MEM_WD = 145;
  localparam int MEM_TO_WB_WD = 136;
  localparam int MEM_TO_ID_WD = 104;

  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  typedef struct packed {
    logic [65:0] hilo_bus;
    logic [2:0]  ld_type;
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel_ld;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef struct packed {
    logic [65:0] hilo_bus;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_wb_t;

  typedef struct packed {
    logic [65:0] hilo_bus;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } mem_id_t;

endpackage

// File: rtl/mem_stage_if.sv
// MEM stage bus bundle: EX input, SRAM data,
// WB/ID outputs and the misaligned-load flag.
interface mem_stage_if import mem_stage_pkg::*; ();

  logic [STALL_W-1:0] stall;
  ex_mem_t            ex_to_mem_bus;
  logic [31:0]        data_sram_rdata;
  mem_wb_t            mem_to_wb_bus;
  mem_id_t            mem_to_id_bus;
  logic               mem_excp;

  modport master (
    output stall,
    output ex_to_mem_bus,
    output data_sram_rdata,
    input  mem_to_wb_bus,
    input  mem_to_id_bus,
    input  mem_excp
  );

  modport slave (
    input  stall,
    input  ex_to_mem_bus,
    input  data_sram_rdata,
    output mem_to_wb_bus,
    output mem_to_id_bus,
    output mem_excp
  );

endinterface

// File: rtl/mem_load_align.sv
// Load data lane select and sign/zero extension.
// Reserved load types behave as LW.
module mem_load_align import mem_stage_pkg::*; (
  input  logic [2:0]  ld_type,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        is_b;
  logic        is_h;
  logic        sx;

  // pick the addressed byte/half and extend it
  always_comb begin
    lane_b = rdata[7:0];
    unique case (addr)
      2'd0: lane_b = rdata[7:0];
      2'd1: lane_b = rdata[15:8];
      2'd2: lane_b = rdata[23:16];
      2'd3: lane_b = rdata[31:24];
    endcase
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    is_b   = (ld_type == LD_LB) || (ld_type == LD_LBU);
    is_h   = (ld_type == LD_LH) || (ld_type == LD_LHU);
    sx     = (ld_type == LD_LB) || (ld_type == LD_LH);
    load_data = rdata;
    misalign  = 1'b0;
    unique case (1'b1)
      is_b: load_data = {{24{sx & lane_b[7]}}, lane_b};
      is_h: begin
        load_data = {{16{sx & lane_h[15]}}, lane_h};
        misalign  = addr[0];
      end
      default: misalign = (addr != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// SampleCPU MEM stage: pipeline register, load align, result mux.
// Optional misaligned-load trap: define MEM_ALIGN_CHK_EN.
module mem_stage import mem_stage_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  ex_mem_t     ex_to_mem_bus_r;
  logic [31:0] load_data;
  logic        misalign;
  logic        is_load;
  logic        excp;
  logic [31:0] rf_wdata;
  logic        rf_we;

  // EX->MEM register: bubble on reset or MEM stop with WB running
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_to_mem_bus_r <= '0;
    end else if (bus.stall[STALL_MEM] == STOP &&
                 bus.stall[STALL_WB] == NO_STOP) begin
      ex_to_mem_bus_r <= '0;
    end else if (bus.stall[STALL_MEM] == NO_STOP) begin
      ex_to_mem_bus_r <= bus.ex_to_mem_bus;
    end
  end

  mem_load_align u_align (
    .ld_type   (ex_to_mem_bus_r.ld_type),
    .addr      (ex_to_mem_bus_r.ex_result[1:0]),
    .rdata     (bus.data_sram_rdata),
    .load_data (load_data),
    .misalign  (misalign)
  );

  assign is_load = ex_to_mem_bus_r.sel_ld &&
                   ex_to_mem_bus_r.ram_en &&
                   (ex_to_mem_bus_r.ram_wen == 4'b0000);

`ifdef MEM_ALIGN_CHK_EN
  assign excp = is_load & misalign;
`else
  logic unused_misalign;
  assign unused_misalign = misalign;
  assign excp = 1'b0;
`endif

  // result mux; a trapped load never writes the RF
  always_comb begin
    rf_wdata = is_load ? load_data : ex_to_mem_bus_r.ex_result;
    rf_we    = ex_to_mem_bus_r.rf_we & ~excp;
  end

  // pack WB and bypass buses
  always_comb begin
    bus.mem_to_wb_bus.hilo_bus = ex_to_mem_bus_r.hilo_bus;
    bus.mem_to_wb_bus.pc       = ex_to_mem_bus_r.pc;
    bus.mem_to_wb_bus.rf_we    = rf_we;
    bus.mem_to_wb_bus.rf_waddr = ex_to_mem_bus_r.rf_waddr;
    bus.mem_to_wb_bus.rf_wdata = rf_wdata;
    bus.mem_to_id_bus.hilo_bus = ex_to_mem_bus_r.hilo_bus;
    bus.mem_to_id_bus.rf_we    = rf_we;
    bus.mem_to_id_bus.rf_waddr = ex_to_mem_bus_r.rf_waddr;
    bus.mem_to_id_bus.rf_wdata = rf_wdata;
    bus.mem_excp               = excp;
  end

endmodule
